// File: rtl/viterbi_step_ctrl.sv
// Frame sequencer for the rate-1/2 K=7 hard-decision Viterbi decoder: feeds one symbol pair per
// trellis step to the BMC/ACS arrays, writes survivor memory, then sweeps traceback addresses.
module viterbi_step_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL      = 6,
    parameter int AW        = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    rx_pair,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [1:0]    bmc_pair,
    output logic          acs_en,
    output logic          pm_init,
    input  logic          norm_req,
    output logic          norm_en,
    output logic          sm_wr_en,
    output logic [AW-1:0] sm_addr,
    output logic          tb_en,
    output logic          tb_last,
    output logic          busy,
    output logic          frame_done
);

    localparam int N = FRAME_LEN + TAIL;
    localparam logic [AW-1:0] LAST_STEP = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_TB,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] step_cnt_q;
    logic [AW-1:0] step_cnt_d;
    logic          xfer;

    logic          rx_ready_p0;
    logic          rx_ready_p1;
    logic [1:0]    bmc_pair_p0;
    logic [1:0]    bmc_pair_p1;
    logic          vld_p0;
    logic          vld_p1;
    logic          pm_init_p0;
    logic          pm_init_p1;
    logic          norm_en_p0;
    logic          norm_en_p1;
    logic [AW-1:0] sm_addr_p0;
    logic [AW-1:0] sm_addr_p1;
    logic          tb_en_p0;
    logic          tb_en_p1;
    logic          tb_last_p0;
    logic          tb_last_p1;
    logic          busy_p0;
    logic          busy_p1;
    logic          frame_done_p0;
    logic          frame_done_p1;

    // rx_ready is itself a register, so accepting a pair never depends combinationally on outputs
    assign xfer = rx_valid & rx_ready_p1;

    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        rx_ready_p0   = 1'b0;
        bmc_pair_p0   = bmc_pair_p1;
        vld_p0        = 1'b0;
        pm_init_p0    = 1'b0;
        norm_en_p0    = 1'b0;
        sm_addr_p0    = sm_addr_p1;
        tb_en_p0      = 1'b0;
        tb_last_p0    = 1'b0;
        frame_done_p0 = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    step_cnt_d  = '0;
                    rx_ready_p0 = 1'b1;
                end
            end
            S_RUN: begin
                rx_ready_p0 = 1'b1;
                if (xfer) begin
                    bmc_pair_p0 = rx_pair;
                    vld_p0      = 1'b1;
                    pm_init_p0  = (step_cnt_q == '0);
                    norm_en_p0  = norm_req;
                    sm_addr_p0  = step_cnt_q;
                    step_cnt_d  = step_cnt_q + 1'b1;
                    if (step_cnt_q == LAST_STEP) begin
                        state_d     = S_DRAIN;
                        rx_ready_p0 = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                state_d    = S_TB;
                tb_en_p0   = 1'b1;
                sm_addr_p0 = LAST_STEP;
                tb_last_p0 = (LAST_STEP == '0);
            end
            S_TB: begin
                if (sm_addr_p1 == '0) begin
                    state_d       = S_DONE;
                    frame_done_p0 = 1'b1;
                    step_cnt_d    = '0;
                end else begin
                    tb_en_p0   = 1'b1;
                    sm_addr_p0 = sm_addr_p1 - 1'b1;
                    tb_last_p0 = (sm_addr_p1 == AW'(1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_p0 = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_TB);
    end

    // p0 -> p1: every output is taken straight from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            step_cnt_q    <= '0;
            rx_ready_p1   <= 1'b0;
            bmc_pair_p1   <= 2'b00;
            vld_p1        <= 1'b0;
            pm_init_p1    <= 1'b0;
            norm_en_p1    <= 1'b0;
            sm_addr_p1    <= '0;
            tb_en_p1      <= 1'b0;
            tb_last_p1    <= 1'b0;
            busy_p1       <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            rx_ready_p1   <= rx_ready_p0;
            bmc_pair_p1   <= bmc_pair_p0;
            vld_p1        <= vld_p0;
            pm_init_p1    <= pm_init_p0;
            norm_en_p1    <= norm_en_p0;
            sm_addr_p1    <= sm_addr_p0;
            tb_en_p1      <= tb_en_p0;
            tb_last_p1    <= tb_last_p0;
            busy_p1       <= busy_p0;
            frame_done_p1 <= frame_done_p0;
        end
    end

    assign rx_ready   = rx_ready_p1;
    assign bmc_pair   = bmc_pair_p1;
    assign acs_en     = vld_p1;
    assign sm_wr_en   = vld_p1;
    assign pm_init    = pm_init_p1;
    assign norm_en    = norm_en_p1;
    assign sm_addr    = sm_addr_p1;
    assign tb_en      = tb_en_p1;
    assign tb_last    = tb_last_p1;
    assign busy       = busy_p1;
    assign frame_done = frame_done_p1;

endmodule
